// File: rtl/fetch_stall_controller.sv
// Fetch-stage controller: owns the PC, the IF/ID register and the ID/EX bubble
// request, and keeps stall-cycle statistics for performance monitoring.
module fetch_stall_controller #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned     CNT_W     = 16,
  parameter int unsigned     MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             IF_pipeline_write_zero,
  input  logic             pc_write_zero,
  input  logic             branch_taken_E,
  input  logic [XLEN-1:0]  branch_target_E,
  input  logic [XLEN-1:0]  instr_F,
  input  logic             instr_valid_F,
  output logic [XLEN-1:0]  pc_F,
  output logic [XLEN-1:0]  instr_D,
  output logic [XLEN-1:0]  pc_D,
  output logic [XLEN-1:0]  pc_plus4_D,
  output logic             valid_D,
  output logic             bubble_E,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_err
);

  // Handshake: instr_valid_F qualifies instr_F for the current pc_F. There is no
  // ready; back-pressure is expressed by holding pc_F (pc_write_zero), so imem
  // simply re-presents the same address until it returns valid data.

  localparam int unsigned     CS_W   = $clog2(MAX_STALL + 1);
  localparam logic [CS_W-1:0] CS_MAX = CS_W'(MAX_STALL);
  localparam logic [CS_W:0]   CS_LIM = (CS_W + 1)'(MAX_STALL);

  logic [XLEN-1:0] pc_plus4_F;
  logic [XLEN-1:0] redirect_pc;
  logic [CS_W-1:0] cs_q;
  logic [CS_W:0]   cs_inc;
  logic            cs_hits_max;
  logic            count_sat;

  // Targets are word aligned; the low bits from EX are discarded.
  assign redirect_pc = {branch_target_E[XLEN-1:2], 2'b00};
  assign pc_plus4_F  = pc_F + XLEN'(4);

  assign cs_inc      = {1'b0, cs_q} + (CS_W + 1)'(1);
  assign cs_hits_max = stall && (cs_inc >= CS_LIM);
  assign count_sat   = (stall_count == {CNT_W{1'b1}});

  // Bubble reaches the ID/EX register at the same edge, so it must be combinational.
  assign bubble_E = !reset && (stall || branch_taken_E);

  // PC register: redirect beats every hold request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_F <= RESET_PC;
    end else if (branch_taken_E) begin
      pc_F <= redirect_pc;
    end else if (pc_write_zero) begin
      pc_F <= pc_F;
    end else if (!instr_valid_F) begin
      pc_F <= pc_F;
    end else begin
      pc_F <= pc_plus4_F;
    end
  end

  // IF/ID register: a hold keeps the stalled instruction even if imem goes invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_D    <= NOP_INSTR;
      pc_D       <= '0;
      pc_plus4_D <= '0;
      valid_D    <= 1'b0;
    end else if (branch_taken_E) begin
      instr_D    <= NOP_INSTR;
      pc_D       <= '0;
      pc_plus4_D <= '0;
      valid_D    <= 1'b0;
    end else if (IF_pipeline_write_zero) begin
      instr_D    <= instr_D;
      pc_D       <= pc_D;
      pc_plus4_D <= pc_plus4_D;
      valid_D    <= valid_D;
    end else if (!instr_valid_F) begin
      instr_D    <= NOP_INSTR;
      pc_D       <= '0;
      pc_plus4_D <= '0;
      valid_D    <= 1'b0;
    end else begin
      instr_D    <= instr_F;
      pc_D       <= pc_F;
      pc_plus4_D <= pc_plus4_F;
      valid_D    <= 1'b1;
    end
  end

  // Consecutive-stall tracking; counts even when a redirect wins the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q      <= '0;
      stall_err <= 1'b0;
    end else begin
      if (!stall) begin
        cs_q <= '0;
      end else if (cs_q != CS_MAX) begin
        cs_q <= cs_inc[CS_W-1:0];
      end
      if (cs_hits_max) begin
        stall_err <= 1'b1;
      end
    end
  end

  // Lifetime stall cycles, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && !count_sat) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Directed bench for fetch_stall_controller: hand-computed expectations for reset,
// sequential fetch, stalls, redirects, PC wrap, invalid fetch and counter saturation.
module tb_fetch_stall_controller;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] I0    = 32'h0050_0093;
  localparam logic [31:0] I1    = 32'h0010_0113;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             IF_pipeline_write_zero;
  logic             pc_write_zero;
  logic             branch_taken_E;
  logic [XLEN-1:0]  branch_target_E;
  logic [XLEN-1:0]  instr_F;
  logic             instr_valid_F;
  logic [XLEN-1:0]  pc_F;
  logic [XLEN-1:0]  instr_D;
  logic [XLEN-1:0]  pc_D;
  logic [XLEN-1:0]  pc_plus4_D;
  logic             valid_D;
  logic             bubble_E;
  logic [CNT_W-1:0] stall_count;
  logic             stall_err;

  int checks = 0;
  int errors = 0;

  fetch_stall_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .IF_pipeline_write_zero(IF_pipeline_write_zero), .pc_write_zero(pc_write_zero),
    .branch_taken_E(branch_taken_E), .branch_target_E(branch_target_E),
    .instr_F(instr_F), .instr_valid_F(instr_valid_F),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .pc_plus4_D(pc_plus4_D),
    .valid_D(valid_D), .bubble_E(bubble_E), .stall_count(stall_count),
    .stall_err(stall_err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_hazard(input logic s);
    stall                  = s;
    IF_pipeline_write_zero = s;
    pc_write_zero          = s;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pcd,
                            input logic [31:0] pc4, input logic v);
    check({tag, ".instr_D"}, instr_D, ins);
    check({tag, ".pc_D"}, pc_D, pcd);
    check({tag, ".pc_plus4_D"}, pc_plus4_D, pc4);
    check({tag, ".valid_D"}, 32'(valid_D), 32'(v));
  endtask

  initial begin
    reset = 1'b1; set_hazard(1'b1); branch_taken_E = 1'b0; branch_target_E = '0;
    instr_F = I0; instr_valid_F = 1'b1;
    @(negedge clk);
    #1 check("reset.bubble_masked", 32'(bubble_E), 32'd0);
    set_hazard(1'b0);
    tick(); tick();
    check("reset.pc_F", pc_F, 32'h0);
    check_ifid("reset", NOP, 32'h0, 32'h0, 1'b0);
    check("reset.stall_count", 32'(stall_count), 32'd0);
    check("reset.stall_err", 32'(stall_err), 32'd0);

    // First fetch after reset
    reset = 1'b0;
    tick();
    check_ifid("fetch0", I0, 32'h0, 32'h4, 1'b1);
    check("fetch0.pc_F", pc_F, 32'h4);
    tick();
    check("fetch1.pc_F", pc_F, 32'h8);
    tick(); tick();
    check("fetch3.pc_F", pc_F, 32'h10);
    check_ifid("fetch3", I0, 32'hC, 32'h10, 1'b1);

    // One-cycle load-use stall: everything holds, bubble requested
    set_hazard(1'b1); instr_F = I1;
    #1 check("stall1.bubble_E", 32'(bubble_E), 32'd1);
    tick();
    check("stall1.pc_F", pc_F, 32'h10);
    check_ifid("stall1", I0, 32'hC, 32'h10, 1'b1);
    check("stall1.stall_count", 32'(stall_count), 32'd1);
    check("stall1.stall_err", 32'(stall_err), 32'd0);
    set_hazard(1'b0);
    #1 check("nostall.bubble_E", 32'(bubble_E), 32'd0);
    tick();
    check("resume.pc_F", pc_F, 32'h14);
    check_ifid("resume", I1, 32'h10, 32'h14, 1'b1);

    // Redirect together with a stall: redirect and flush win, stall still counted
    set_hazard(1'b1); branch_taken_E = 1'b1; branch_target_E = 32'h103;
    #1 check("branch.bubble_E", 32'(bubble_E), 32'd1);
    tick();
    check("branch.pc_F", pc_F, 32'h100);
    check_ifid("branch", NOP, 32'h0, 32'h0, 1'b0);
    check("branch.stall_count", 32'(stall_count), 32'd2);
    set_hazard(1'b0); branch_taken_E = 1'b0;
    tick();
    check("post_branch.pc_F", pc_F, 32'h104);
    check_ifid("post_branch", I1, 32'h100, 32'h104, 1'b1);

    // Long stall; imem also goes invalid on the last cycle, and the hold must win
    set_hazard(1'b1);
    tick(); tick(); tick();
    check("long3.stall_err", 32'(stall_err), 32'd0);
    instr_valid_F = 1'b0;
    tick();
    check("long4.stall_err", 32'(stall_err), 32'd1);
    check("long4.stall_count", 32'(stall_count), 32'd6);
    check("long4.pc_F", pc_F, 32'h104);
    check_ifid("long4_hold", I1, 32'h100, 32'h104, 1'b1);
    set_hazard(1'b0); instr_valid_F = 1'b1;
    tick();
    check("sticky.stall_err", 32'(stall_err), 32'd1);
    check("sticky.stall_count", 32'(stall_count), 32'd6);

    // Reset arriving mid-stall and mid-branch overrides everything
    reset = 1'b1; set_hazard(1'b1); branch_taken_E = 1'b1; branch_target_E = 32'h200;
    #1 check("reset_mid.bubble_E", 32'(bubble_E), 32'd0);
    tick();
    check("reset_mid.pc_F", pc_F, 32'h0);
    check("reset_mid.stall_err", 32'(stall_err), 32'd0);
    check("reset_mid.stall_count", 32'(stall_count), 32'd0);
    check_ifid("reset_mid", NOP, 32'h0, 32'h0, 1'b0);

    // PC wrap: redirect to the last word (low target bits dropped), then fetch
    reset = 1'b0; set_hazard(1'b0); branch_target_E = 32'hFFFF_FFFE;
    tick();
    check("wrap_br.pc_F", pc_F, 32'hFFFF_FFFC);
    branch_taken_E = 1'b0;
    tick();
    check("wrap.pc_F", pc_F, 32'h0);
    check_ifid("wrap", I1, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // imem invalid for two cycles without a stall
    instr_valid_F = 1'b0;
    tick();
    check("inv1.pc_F", pc_F, 32'h0);
    check_ifid("inv1", NOP, 32'h0, 32'h0, 1'b0);
    tick();
    check("inv2.pc_F", pc_F, 32'h0);
    check_ifid("inv2", NOP, 32'h0, 32'h0, 1'b0);
    instr_valid_F = 1'b1; instr_F = I0;
    tick();
    check("inv_resume.pc_F", pc_F, 32'h4);
    check_ifid("inv_resume", I0, 32'h0, 32'h4, 1'b1);

    // Stall counter saturation (4-bit instance saturates at 15)
    set_hazard(1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("sat15.stall_count", 32'(stall_count), 32'd15);
    tick(); tick();
    check("sat17.stall_count", 32'(stall_count), 32'd15);
    check("sat17.stall_err", 32'(stall_err), 32'd1);
    set_hazard(1'b0);
    tick();
    check("sat_end.stall_count", 32'(stall_count), 32'd15);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
